// File: rtl/wb_uart_tx_fifo_pkg.sv
// Shared definitions for the Wishbone UART transmitter.
//   tx_state_e    : serialiser state encoding
//   PARITY_*      : parity mode selectors
//   STAT_*        : bit positions inside the status byte returned on reads
//   parity_bit()  : parity bit for the low dbits bits of a character
package wb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_LEVEL_LSB = 3;

    // Odd mode makes data+parity carry an odd number of ones, even mode an even number.
    function automatic logic parity_bit(input logic [7:0] data, input int dbits, input int mode);
        logic ones;
        ones = ^(data & (8'hFF >> (8 - dbits)));
        return (mode == PARITY_ODD) ? ~ones : ones;
    endfunction

endpackage

// File: rtl/wb_uart_tx_fifo_if.sv
// Wishbone slave bus bundle for the UART transmitter.
//   wb_cyc_i/wb_stb_i : request qualifiers
//   wb_we_i           : 1 = queue character, 0 = read status
//   wb_dat_i          : character in
//   wb_dat_o          : status out
//   wb_ack_o          : single-cycle acknowledge
//   wb_stall_o        : pipelined-mode stall (TX queue full)
interface wb_uart_tx_fifo_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       wb_stall_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO holding queued TX characters.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset (flushes the queue)
//   i_push, i_wdata    : enqueue (ignored when full)
//   i_pop              : dequeue (ignored when empty)
//   o_rdata            : head entry, valid while !o_empty
//   o_full, o_empty    : registered-count flags
//   o_level            : number of entries, 0..DEPTH
module wb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_full    = (r_count == LW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates visibility.
    always_ff @(posedge wb_clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/wb_uart_tx_fifo.sv
// Wishbone UART transmitter with a TX queue; frames leave back-to-back.
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset (truncates frame, flushes queue)
//   wb       : Wishbone slave bundle (write = queue char, read = status byte
//              {level[4:0], busy, full, empty})
//   uart_tx  : registered serial line, idle high
module wb_uart_tx_fifo
    import wb_uart_pkg::*;
#(
    parameter int TICKS_PER_BAUD = 16,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_uart_tx_fifo_if.slave    wb,
    output logic                uart_tx
);
    generate
        if (TICKS_PER_BAUD < 2 || TICKS_PER_BAUD > 65535 ||
            DATA_BITS < 5 || DATA_BITS > 8 ||
            PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("wb_uart_tx_fifo: illegal parameter value");
        end
    endgenerate

    localparam int CW = $clog2(TICKS_PER_BAUD);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(TICKS_PER_BAUD - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_e       r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_tx;
    logic            r_ack;
    logic [7:0]      r_dat;

    logic            w_req;
    logic            w_wr;
    logic            w_rd;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_baud_end;
    logic            w_frame_end;
    logic [7:0]      w_fifo_data;
    logic [LW-1:0]   w_level;
    logic [7:0]      w_status;

    assign w_req       = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_wr        = w_req & wb.wb_we_i & ~w_full;
    assign w_rd        = w_req & ~wb.wb_we_i;
    assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
    assign w_frame_end = (r_state == ST_STOP) & w_baud_end & (r_bit_idx == STOP_LAST);
    // Pop either from idle or on the last stop edge so frames chain without a gap.
    assign w_pop       = ~w_empty & ((r_state == ST_IDLE) | w_frame_end);

    assign wb.wb_stall_o = w_full;
    assign wb.wb_ack_o   = r_ack;
    assign wb.wb_dat_o   = r_dat;
    assign uart_tx       = r_tx;

    wb_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .i_push   (w_wr),
        .i_wdata  (wb.wb_dat_i),
        .i_pop    (w_pop),
        .o_rdata  (w_fifo_data),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (w_level)
    );

    // Status byte assembled from the current registered state.
    always_comb begin
        w_status = 8'h00;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_BUSY]  = (r_state != ST_IDLE);
        w_status[STAT_LEVEL_LSB +: 5] = 5'(w_level);
    end

    // Wishbone response: one ack per accepted request, read data latched with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 8'h01;
        end else begin
            r_ack <= w_wr | w_rd;
            if (w_rd) r_dat <= w_status;
            else      r_dat <= r_dat;
        end
    end

    // Serialiser FSM; a pop always starts a new frame, regardless of current state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_pop) begin
            r_state    <= ST_START;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= w_fifo_data;
            r_par      <= parity_bit(w_fifo_data, DATA_BITS, PARITY);
            r_tx       <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
        end else if (!w_baud_end) begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
        end else begin
            r_baud_cnt <= '0;
            case (r_state)
                ST_START: begin
                    r_state   <= ST_DATA;
                    r_bit_idx <= 3'd0;
                    r_tx      <= r_shift[0];
                end
                ST_DATA: begin
                    if (r_bit_idx == DATA_LAST) begin
                        r_bit_idx <= 3'd0;
                        if (PARITY != PARITY_NONE) begin
                            r_state <= ST_PARITY;
                            r_tx    <= r_par;
                        end else begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_tx      <= r_shift[1];
                    end
                end
                ST_PARITY: begin
                    r_state   <= ST_STOP;
                    r_bit_idx <= 3'd0;
                    r_tx      <= 1'b1;
                end
                ST_STOP: begin
                    // Last stop bit with an empty queue: go idle (pop case handled above).
                    if (r_bit_idx == STOP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    r_tx <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// Self-checking bench: three configurations (8N1, 7E2, 7O2) driven one at a time
// and compared every cycle against a frame-level reference model.
module tb_wb_uart_tx_fifo;
    localparam int TPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       b_cyc;
    logic       b_we;
    logic [7:0] b_dat;
    int         sel;

    logic tx_a, tx_b, tx_c;
    wb_uart_tx_fifo_if if_a ();
    wb_uart_tx_fifo_if if_b ();
    wb_uart_tx_fifo_if if_c ();

    assign if_a.wb_cyc_i = b_cyc & (sel == 0);
    assign if_a.wb_stb_i = b_cyc & (sel == 0);
    assign if_a.wb_we_i  = b_we;
    assign if_a.wb_dat_i = b_dat;
    assign if_b.wb_cyc_i = b_cyc & (sel == 1);
    assign if_b.wb_stb_i = b_cyc & (sel == 1);
    assign if_b.wb_we_i  = b_we;
    assign if_b.wb_dat_i = b_dat;
    assign if_c.wb_cyc_i = b_cyc & (sel == 2);
    assign if_c.wb_stb_i = b_cyc & (sel == 2);
    assign if_c.wb_we_i  = b_we;
    assign if_c.wb_dat_i = b_dat;

    wb_uart_tx_fifo #(.TICKS_PER_BAUD(TPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if_a), .uart_tx(tx_a));
    wb_uart_tx_fifo #(.TICKS_PER_BAUD(TPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if_b), .uart_tx(tx_b));
    wb_uart_tx_fifo #(.TICKS_PER_BAUD(TPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut_c (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if_c), .uart_tx(tx_c));

    logic       obs_tx, obs_ack, obs_stall;
    logic [7:0] obs_dat;
    always_comb begin
        case (sel)
            1:       begin obs_tx = tx_b; obs_ack = if_b.wb_ack_o; obs_stall = if_b.wb_stall_o; obs_dat = if_b.wb_dat_o; end
            2:       begin obs_tx = tx_c; obs_ack = if_c.wb_ack_o; obs_stall = if_c.wb_stall_o; obs_dat = if_c.wb_dat_o; end
            default: begin obs_tx = tx_a; obs_ack = if_a.wb_ack_o; obs_stall = if_a.wb_stall_o; obs_dat = if_a.wb_dat_o; end
        endcase
    end

    // Reference model: queued characters plus the remaining line levels of the current frame.
    logic [7:0] fifo_q [$];
    bit         line_q [$];
    bit         obs_log [$];
    logic       m_busy;
    logic       exp_tx, exp_ack, exp_stall;
    logic [7:0] exp_dat;
    int         m_dbits, m_par, m_stops;
    int         checks, errors;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic push_bit(input bit b);
        repeat (TPB) line_q.push_back(b);
    endtask

    task automatic load_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        push_bit(1'b0);
        for (int i = 0; i < m_dbits; i++) begin
            push_bit(d[i]);
            ones += int'(d[i]);
        end
        if (m_par == 1)      push_bit((ones % 2) == 0);
        else if (m_par == 2) push_bit((ones % 2) == 1);
        for (int i = 0; i < m_stops; i++) push_bit(1'b1);
    endtask

    task automatic model_edge(input logic c, input logic w, input logic [7:0] d);
        int         lvl;
        logic       full_pre, empty_pre;
        logic [7:0] ch;
        if (rst) begin
            fifo_q.delete();
            line_q.delete();
            m_busy  = 1'b0;
            exp_tx  = 1'b1;
            exp_ack = 1'b0;
            exp_dat = 8'h01;
        end else begin
            lvl       = fifo_q.size();
            full_pre  = (lvl == DEPTH);
            empty_pre = (lvl == 0);
            exp_ack   = c & (~w | ~full_pre);
            if (c & ~w) exp_dat = {5'(lvl), m_busy, full_pre, empty_pre};
            if (line_q.size() > 0) begin
                exp_tx = line_q.pop_front();
                m_busy = 1'b1;
            end else if (!empty_pre) begin
                ch = fifo_q.pop_front();
                load_frame(ch);
                exp_tx = line_q.pop_front();
                m_busy = 1'b1;
            end else begin
                exp_tx = 1'b1;
                m_busy = 1'b0;
            end
            if (c & w & ~full_pre) fifo_q.push_back(d);
        end
        exp_stall = (fifo_q.size() == DEPTH);
    endtask

    task automatic step(input logic c, input logic w, input logic [7:0] d);
        b_cyc = c;
        b_we  = w;
        b_dat = d;
        model_edge(c, w, d);
        @(posedge clk);
        #1;
        obs_log.push_back(obs_tx);
        check("tx",    {7'd0, obs_tx},    {7'd0, exp_tx});
        check("ack",   {7'd0, obs_ack},   {7'd0, exp_ack});
        check("stall", {7'd0, obs_stall}, {7'd0, exp_stall});
        check("dat_o", obs_dat, exp_dat);
        b_cyc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic select_dut(input int s);
        sel = s;
        case (s)
            1:       begin m_dbits = 7; m_par = 2; m_stops = 2; end
            2:       begin m_dbits = 7; m_par = 1; m_stops = 2; end
            default: begin m_dbits = 8; m_par = 0; m_stops = 1; end
        endcase
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        obs_log.delete();
    endtask

    task automatic random_run(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       step(1'b1, 1'b1, 8'($urandom));
            else if (r == 4) step(1'b1, 1'b0, 8'($urandom));
            else             step(1'b0, 1'b0, 8'h00);
        end
        idle(260);
    endtask

    initial begin
        logic [9:0] pat;
        checks = 0;
        errors = 0;
        b_cyc  = 1'b0;
        b_we   = 1'b0;
        b_dat  = 8'h00;

        // Reset values on all three instances.
        select_dut(0);
        check("rst_tx_a",  {7'd0, tx_a}, 8'h01);
        check("rst_tx_b",  {7'd0, tx_b}, 8'h01);
        check("rst_tx_c",  {7'd0, tx_c}, 8'h01);
        check("rst_dat_b", if_b.wb_dat_o, 8'h01);
        check("rst_dat_c", if_c.wb_dat_o, 8'h01);
        check("rst_ack_b", {7'd0, if_b.wb_ack_o}, 8'h00);
        check("rst_stall_c", {7'd0, if_c.wb_stall_o}, 8'h00);

        // 8N1 single character 0xA5: frame bits in send order, bit 0 first.
        pat = 10'b11_0100_1010;
        step(1'b1, 1'b1, 8'hA5);
        check("a5_ack", {7'd0, obs_ack}, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        check("a5_ack_once", {7'd0, obs_ack}, 8'h00);
        idle(43);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < TPB; k++)
                check("a5_bit", {7'd0, obs_log[1 + i*TPB + k]}, {7'd0, pat[i]});
        for (int k = 41; k < 45; k++) check("a5_idle", {7'd0, obs_log[k]}, 8'h01);

        // Status while idle and empty, then with two characters queued behind a frame.
        step(1'b1, 1'b0, 8'h00);
        check("stat_idle", obs_dat, 8'h01);
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        step(1'b1, 1'b0, 8'h00);
        check("stat_busy2", obs_dat, 8'h14);
        idle(160);

        // Burst behind an active frame: four accepted, fifth stalled.
        step(1'b1, 1'b1, 8'h00);
        idle(2);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(i));
        check("burst_5th_ack", {7'd0, obs_ack}, 8'h00);
        check("burst_stall", {7'd0, obs_stall}, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        check("burst_stat", obs_dat, 8'h26);
        idle(240);

        // Write landing on the edge that ends the last stop bit with an empty queue.
        step(1'b1, 1'b1, 8'h3C);
        idle(40);
        step(1'b1, 1'b1, 8'hC3);
        check("edge_wr_idle", {7'd0, obs_tx}, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        check("edge_wr_start", {7'd0, obs_tx}, 8'h00);
        idle(48);

        // Reset in the middle of a data bit with three characters queued.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
        idle(10);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("midrst_tx", {7'd0, obs_tx}, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        check("midrst_stat", obs_dat, 8'h01);
        idle(100);

        random_run(400);

        // 7E2 and 7O2 with 0x55: parity bit sits at bit position 8 of the frame.
        select_dut(1);
        step(1'b1, 1'b1, 8'h55);
        idle(48);
        check("7e2_par", {7'd0, obs_log[1 + 8*TPB]}, 8'h00);
        check("7e2_stop", {7'd0, obs_log[1 + 9*TPB]}, 8'h01);
        random_run(200);

        select_dut(2);
        step(1'b1, 1'b1, 8'h55);
        idle(48);
        check("7o2_par", {7'd0, obs_log[1 + 8*TPB]}, 8'h01);
        check("7o2_par_end", {7'd0, obs_log[8*TPB + TPB]}, 8'h01);
        random_run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx_fifo.md
Name: wb_uart_tx_fifo

Overview:
Parametrised Wishbone UART transmitter that serialises frames with configurable data width, parity and stop bits. A small synchronous FIFO lets software queue several characters, and frames are sent back-to-back with no idle gap. It sits on the peripheral Wishbone bus as a slave: writes queue characters, reads return TX status.

Parameters:
TICKS_PER_BAUD, 16, clock cycles per bit; legal range 2..65535; counter width is $clog2(TICKS_PER_BAUD).
DATA_BITS, 8, data bits per frame; legal 5..8.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
FIFO_DEPTH, 4, TX queue entries; power of two, 2..16.

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write a character, 0 = read status
wb_dat_i  in  8  character; bits [DATA_BITS-1:0] used, upper bits ignored
wb_dat_o  out  8  status: [0] empty, [1] full, [2] busy, [7:3] FIFO level 0..16
wb_ack_o  out  1  single-cycle acknowledge
wb_stall_o  out  1  pipelined-mode stall
uart_tx  out  1  serial line; idle high

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: uart_tx=1, wb_ack_o=0, wb_stall_o=0, wb_dat_o=0x01 (empty), FIFO empty, state IDLE, all counters 0.
- Request: cyc&stb sampled at a rising edge.
- Write accepted (request & we & !stall at edge N):
  - FIFO pushes wb_dat_i.
  - wb_ack_o=1 for exactly the cycle after N.
- Write while full: wb_stall_o=1, so the write is not accepted, not pushed and not acked.
- wb_stall_o = FIFO full, from the registered count. It stays asserted even if a pop happens on the same edge.
- Read (request & !we): never stalls. wb_ack_o=1 next cycle, wb_dat_o holds the status sampled at edge N. No side effects.
- Frame format:
  - Start bit 0.
  - DATA_BITS data bits, LSB first.
  - Optional parity bit. Odd: total ones in data+parity is odd. Even: total is even.
  - STOP_BITS ones.
  - Every bit lasts exactly TICKS_PER_BAUD cycles.
- States: IDLE, START, DATA, PARITY, STOP. A bit index counts DATA_BITS and STOP_BITS.
- IDLE -> START: when the FIFO is non-empty, pop the entry and load the shifter. uart_tx goes low after that edge.
  - Write to an idle, empty block at edge N: pop at N+1; uart_tx low from N+1 to N+1+TICKS_PER_BAUD.
- START -> DATA -> PARITY (skipped if PARITY=0) -> STOP. Each transition occurs when baud_cnt==TICKS_PER_BAUD-1, and baud_cnt wraps to 0 on that edge.
- End of last stop bit:
  - FIFO non-empty: pop on the same edge and enter START directly. No idle cycles between frames.
  - FIFO empty: enter IDLE.
- Simultaneous push and pop on one edge: level unchanged, data preserved in order.
- busy = state != IDLE.
- uart_tx is registered and glitch-free.
- Reset mid-frame: on the reset edge, uart_tx returns to 1, the frame is truncated, the FIFO is flushed and any pending ack is dropped.
- Illegal parameter values are rejected by an elaboration-time check.
- Formal invariants:
  - baud_cnt < TICKS_PER_BAUD.
  - level <= FIFO_DEPTH.
  - In IDLE: baud_cnt==0 and uart_tx==1.
  - wb_ack_o is never high for 2 consecutive cycles on a single request.

Decomposition:
- Package wb_uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP.
  - Parity constants: PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - Status bit positions: STAT_EMPTY=0, STAT_FULL=1, STAT_BUSY=2, STAT_LEVEL_LSB=3.
- One sub-module, wb_sync_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty and level outputs, wb_clk_i/wb_rst_i.
- The serialiser FSM and Wishbone glue stay in the top module.

Test Plan:
- 8N1, TICKS_PER_BAUD=4: write 0xA5 -> ack 1 cycle later. uart_tx gives 0,1,0,1,0,0,1,0,1,1 over 40 cycles, each level held 4 cycles, then stays 1 with busy=0.
- 7E2, TICKS_PER_BAUD=4: write 0x55, only bits [6:0] used (data 0x55 has four ones) -> parity bit 0. Frame = 0,1,0,1,0,1,0,1,0,1,1, which is 11 bits / 44 cycles. The same stimulus with odd parity sends parity bit 1.
- FIFO_DEPTH=4: burst-write 0x01..0x05 in a clean test (no concurrent pop) -> first 4 acked, stall on the 5th, status level=4 and full=1. Frames then go back-to-back with no idle cycle between the final stop bit and the next start bit.
- Read status while idle and empty -> wb_dat_o=0x01 on the ack cycle. Read during a frame with 2 queued -> 0x14 (level=2, busy=1).
- Reset asserted mid data bit with 3 entries queued -> uart_tx=1 the next cycle. Status reads 0x01 and no further frames are sent.
- Write arriving in the same cycle the final stop bit ends with the FIFO empty -> block enters IDLE, then pops the next cycle. Start bit begins exactly 1 cycle later and the character is neither lost nor duplicated.
